// File: rtl/sd_card_ctrl.sv
// rtl/sd_card_ctrl.sv - SD card init sequencer (CMD0/55/41/16) and single-block CMD17/CMD24 issue
module sd_card_ctrl #(
  parameter int          POWER_CYCLES   = 80,
  parameter int          RSP_TIMEOUT    = 4096,
  parameter logic [15:0] ACMD41_RETRIES = 16'd1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_init,
  input  logic        i_rd_req,
  input  logic        i_wr_req,
  input  logic [31:0] i_block_addr,
  output logic        o_send_cmd,
  output logic [2:0]  o_cmd_select,
  output logic [31:0] o_cmd_arg,
  input  logic        i_cmd_confirm,
  input  logic [7:0]  i_cmd_status,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_init_error,
  output logic        o_op_done,
  output logic        o_op_error,
  output logic [7:0]  o_error_code
);

  localparam logic [2:0]  SEL_CMD0     = 3'd1;
  localparam logic [2:0]  SEL_CMD16    = 3'd2;
  localparam logic [2:0]  SEL_CMD17    = 3'd3;
  localparam logic [2:0]  SEL_CMD24    = 3'd4;
  localparam logic [2:0]  SEL_CMD55    = 3'd5;
  localparam logic [2:0]  SEL_CMD41    = 3'd7;
  localparam logic [7:0]  ST_OK        = 8'd1;
  localparam logic [7:0]  ST_IDLE      = 8'd2;
  localparam logic [7:0]  CODE_TIMEOUT = 8'hF0;
  localparam logic [7:0]  CODE_RETRIES = 8'hF1;
  localparam logic [7:0]  CODE_BADCMD  = 8'hF2;
  localparam logic [31:0] PW_LAST      = 32'(POWER_CYCLES - 1);
  localparam logic [31:0] TO_LAST      = 32'(RSP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    UNINIT, POWER_WAIT, ISSUE, WAIT_SENT, WAIT_RSP, EVAL, READY, FAIL
  } state_t;

  typedef enum logic [1:0] {ACT_ISSUE, ACT_INIT_OK, ACT_OP_END, ACT_FAIL} act_t;

  state_t      state;
  logic [31:0] cnt;
  logic [15:0] retry;
  logic [7:0]  rsp_status;
  logic        timed_out;

  act_t        eval_act;
  logic [2:0]  eval_sel;
  logic [31:0] eval_arg;
  logic [7:0]  eval_code;
  logic        retry_load;
  logic        retry_dec;
  logic        is_op;

  // Decode of the finished command's outcome, consumed only in EVAL
  always_comb begin
    eval_act   = ACT_FAIL;
    eval_sel   = SEL_CMD55;
    eval_arg   = '0;
    eval_code  = rsp_status;
    retry_load = 1'b0;
    retry_dec  = 1'b0;
    is_op      = (o_cmd_select == SEL_CMD17) || (o_cmd_select == SEL_CMD24);
    if (timed_out) begin
      eval_code = CODE_TIMEOUT;
      eval_act  = is_op ? ACT_OP_END : ACT_FAIL;
    end else begin
      case (o_cmd_select)
        SEL_CMD0: begin
          if (rsp_status == ST_IDLE) begin
            eval_act   = ACT_ISSUE;
            retry_load = 1'b1;
          end
        end
        SEL_CMD55: begin
          if (rsp_status == ST_OK || rsp_status == ST_IDLE) begin
            eval_act = ACT_ISSUE;
            eval_sel = SEL_CMD41;
          end
        end
        SEL_CMD41: begin
          if (rsp_status == ST_OK) begin
            eval_act = ACT_ISSUE;
            eval_sel = SEL_CMD16;
            eval_arg = 32'd512;
          end else if (rsp_status == ST_IDLE) begin
            if (retry == 16'd0) begin
              eval_code = CODE_RETRIES;
            end else begin
              eval_act  = ACT_ISSUE;
              retry_dec = 1'b1;
            end
          end
        end
        SEL_CMD16: begin
          if (rsp_status == ST_OK) eval_act = ACT_INIT_OK;
        end
        SEL_CMD17, SEL_CMD24: eval_act = ACT_OP_END;
        default: eval_code = CODE_BADCMD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= UNINIT;
      cnt          <= '0;
      retry        <= '0;
      rsp_status   <= '0;
      timed_out    <= 1'b0;
      o_send_cmd   <= 1'b0;
      o_cmd_select <= '0;
      o_cmd_arg    <= '0;
      o_busy       <= 1'b0;
      o_init_done  <= 1'b0;
      o_init_error <= 1'b0;
      o_op_done    <= 1'b0;
      o_op_error   <= 1'b0;
      o_error_code <= '0;
    end else begin
      o_send_cmd <= 1'b0;
      o_op_done  <= 1'b0;
      o_op_error <= 1'b0;
      case (state)
        UNINIT, FAIL: begin
          if (i_start_init) begin
            state        <= POWER_WAIT;
            cnt          <= '0;
            o_busy       <= 1'b1;
            o_init_error <= 1'b0;
          end
        end
        POWER_WAIT: begin
          if (cnt >= PW_LAST) begin
            state        <= ISSUE;
            o_send_cmd   <= 1'b1;
            o_cmd_select <= SEL_CMD0;
            o_cmd_arg    <= '0;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ISSUE: begin
          state     <= WAIT_SENT;
          cnt       <= cnt + 32'd1;
          timed_out <= 1'b0;
        end
        WAIT_SENT: begin
          if (cnt >= TO_LAST) begin
            timed_out <= 1'b1;
            state     <= EVAL;
          end else begin
            cnt <= cnt + 32'd1;
            if (i_cmd_confirm) state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (i_cmd_confirm) begin
            rsp_status <= i_cmd_status;
            state      <= EVAL;
          end else if (cnt >= TO_LAST) begin
            timed_out <= 1'b1;
            state     <= EVAL;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        EVAL: begin
          if (retry_load)     retry <= ACMD41_RETRIES;
          else if (retry_dec) retry <= retry - 16'd1;
          case (eval_act)
            ACT_ISSUE: begin
              state        <= ISSUE;
              o_send_cmd   <= 1'b1;
              o_cmd_select <= eval_sel;
              o_cmd_arg    <= eval_arg;
              cnt          <= '0;
            end
            ACT_INIT_OK: begin
              state       <= READY;
              o_busy      <= 1'b0;
              o_init_done <= 1'b1;
            end
            ACT_OP_END: begin
              state  <= READY;
              o_busy <= 1'b0;
              if (!timed_out && rsp_status == ST_OK) begin
                o_op_done <= 1'b1;
              end else begin
                o_op_error   <= 1'b1;
                o_error_code <= eval_code;
              end
            end
            default: begin
              state        <= FAIL;
              o_busy       <= 1'b0;
              o_init_done  <= 1'b0;
              o_init_error <= 1'b1;
              o_error_code <= eval_code;
            end
          endcase
        end
        READY: begin
          if (i_start_init) begin
            state       <= POWER_WAIT;
            cnt         <= '0;
            o_busy      <= 1'b1;
            o_init_done <= 1'b0;
          end else if (i_rd_req || i_wr_req) begin
            // read takes priority when both arrive together
            state        <= ISSUE;
            o_send_cmd   <= 1'b1;
            o_busy       <= 1'b1;
            o_cmd_select <= i_rd_req ? SEL_CMD17 : SEL_CMD24;
            o_cmd_arg    <= i_block_addr;
            cnt          <= '0;
          end
        end
        default: state <= UNINIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_card_ctrl.sv
// tb/tb_sd_card_ctrl.sv - scoreboard bench for sd_card_ctrl with a reactive card model
module tb_sd_card_ctrl;

  localparam int          PC      = 80;
  localparam int          TO      = 100;
  localparam logic [15:0] RETRIES = 16'd3;

  localparam int EV_CMD = 0, EV_DONE = 1, EV_OPERR = 2, EV_INITOK = 3, EV_INITFAIL = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start_init = 1'b0;
  logic        i_rd_req = 1'b0;
  logic        i_wr_req = 1'b0;
  logic [31:0] i_block_addr = '0;
  logic        o_send_cmd;
  logic [2:0]  o_cmd_select;
  logic [31:0] o_cmd_arg;
  logic        i_cmd_confirm;
  logic [7:0]  i_cmd_status = '0;
  logic        o_busy, o_init_done, o_init_error, o_op_done, o_op_error;
  logic [7:0]  o_error_code;

  logic conf_card = 1'b0;
  logic conf_stray = 1'b0;
  assign i_cmd_confirm = conf_card | conf_stray;

  always #5 i_clk = ~i_clk;

  sd_card_ctrl #(.POWER_CYCLES(PC), .RSP_TIMEOUT(TO), .ACMD41_RETRIES(RETRIES)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start_init(i_start_init),
    .i_rd_req(i_rd_req), .i_wr_req(i_wr_req), .i_block_addr(i_block_addr),
    .o_send_cmd(o_send_cmd), .o_cmd_select(o_cmd_select), .o_cmd_arg(o_cmd_arg),
    .i_cmd_confirm(i_cmd_confirm), .i_cmd_status(i_cmd_status),
    .o_busy(o_busy), .o_init_done(o_init_done), .o_init_error(o_init_error),
    .o_op_done(o_op_done), .o_op_error(o_op_error), .o_error_code(o_error_code)
  );

  typedef struct {
    int          kind;
    int          sel;
    logic [31:0] arg;
    int          code;
  } ev_t;

  ev_t exp_q[$];
  int  card_q[$];   // status per command; -1 means the card never sends the 2nd confirm
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  cmd0_cyc = 0;
  int  last_cmd_cyc = 0;
  int  last_operr_cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic void expect_ev(input int kind, input int sel, input logic [31:0] arg, input int code);
    ev_t e;
    e.kind = kind; e.sel = sel; e.arg = arg; e.code = code;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input int kind, input int sel, input logic [31:0] arg, input int code);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d sel=%0d arg=%0h code=%0h, required none",
               kind, sel, arg, code);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.sel != sel || e.arg != arg || e.code != code) begin
      bad++;
      $display("FAIL event: got kind=%0d sel=%0d arg=%0h code=%0h, required kind=%0d sel=%0d arg=%0h code=%0h",
               kind, sel, arg, code, e.kind, e.sel, e.arg, e.code);
    end
  endtask

  // Card model: first confirm after a short delay, then the status with the second confirm
  initial begin
    int s;
    forever begin
      @(posedge i_clk); #1;
      if (o_send_cmd) begin
        s = (card_q.size() > 0) ? card_q.pop_front() : 1;
        repeat ($urandom_range(1, 4)) @(posedge i_clk);
        #1 conf_card = 1'b1;
        @(posedge i_clk); #1 conf_card = 1'b0;
        if (s >= 0) begin
          repeat ($urandom_range(0, 3)) @(posedge i_clk);
          if ($time % 10 != 6) #1;
          i_cmd_status = 8'(s);
          conf_card = 1'b1;
          @(posedge i_clk); #1 conf_card = 1'b0;
          i_cmd_status = 8'($urandom_range(0, 255));
        end
      end
    end
  end

  // Monitor: every DUT-presented event is popped against the scoreboard
  initial begin
    logic        prev_done, prev_err, have_cmd;
    logic [2:0]  last_sel;
    logic [31:0] last_arg;
    prev_done = 1'b0; prev_err = 1'b0; have_cmd = 1'b0; last_sel = '0; last_arg = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        prev_done = 1'b0; prev_err = 1'b0; have_cmd = 1'b0;
      end else begin
        if (o_send_cmd) begin
          last_cmd_cyc = cyc;
          if (o_cmd_select == 3'd1) cmd0_cyc = cyc;
          last_sel = o_cmd_select; last_arg = o_cmd_arg; have_cmd = 1'b1;
          observe(EV_CMD, int'(o_cmd_select), o_cmd_arg, 0);
        end else if (have_cmd) begin
          check("cmd_stable", {o_cmd_select, o_cmd_arg}, {last_sel, last_arg});
        end
        if (o_op_done) observe(EV_DONE, 0, 0, 0);
        if (o_op_error) begin
          last_operr_cyc = cyc;
          observe(EV_OPERR, 0, 0, int'(o_error_code));
        end
        if (o_init_done && !prev_done) observe(EV_INITOK, 0, 0, 0);
        if (o_init_error && !prev_err) observe(EV_INITFAIL, 0, 0, int'(o_error_code));
        prev_done = o_init_done; prev_err = o_init_error;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    #1;
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("FAIL %s: %0d events pending after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
      card_q.delete();
    end
  endtask

  // Reference: walk the init rules, choosing card statuses and predicting every event
  task automatic model_init(input int k_busy, input int err_pos, input int err_val,
                            output bit ok, output int code);
    int n = 0, busy_seen = 0, r = int'(RETRIES), s;
    ok = 1'b0; code = 0;
    expect_ev(EV_CMD, 1, 0, 0);
    s = (n == err_pos) ? err_val : 2; card_q.push_back(s); n++;
    if (s != 2) begin code = s; expect_ev(EV_INITFAIL, 0, 0, s); return; end
    forever begin
      expect_ev(EV_CMD, 5, 0, 0);
      s = (n == err_pos) ? err_val : int'($urandom_range(1, 2)); card_q.push_back(s); n++;
      if (s != 1 && s != 2) begin code = s; expect_ev(EV_INITFAIL, 0, 0, s); return; end
      expect_ev(EV_CMD, 7, 0, 0);
      s = (n == err_pos) ? err_val : ((busy_seen < k_busy) ? 2 : 1); card_q.push_back(s); n++;
      if (s == 1) break;
      if (s != 2) begin code = s; expect_ev(EV_INITFAIL, 0, 0, s); return; end
      if (r == 0) begin code = 'hF1; expect_ev(EV_INITFAIL, 0, 0, 'hF1); return; end
      r--; busy_seen++;
    end
    expect_ev(EV_CMD, 2, 512, 0);
    s = (n == err_pos) ? err_val : 1; card_q.push_back(s); n++;
    if (s == 1) begin ok = 1'b1; expect_ev(EV_INITOK, 0, 0, 0); end
    else begin code = s; expect_ev(EV_INITFAIL, 0, 0, s); end
  endtask

  task automatic run_init(input int k_busy, input int err_pos, input int err_val);
    bit ok;
    int code;
    model_init(k_busy, err_pos, err_val, ok, code);
    i_start_init = 1'b1;
    @(posedge i_clk); #1;
    start_cyc = cyc;
    i_start_init = 1'b0;
    tick(2);
    check("busy_in_power_wait", o_busy, 1);
    check("init_done_cleared", o_init_done, 0);
    check("init_error_cleared", o_init_error, 0);
    i_start_init = 1'b1;
    tick(1);
    i_start_init = 1'b0;
    drain(3000, "init_sequence");
    check("power_wait_cycles", cmd0_cyc - start_cyc, PC);
    check("busy_after_init", o_busy, 0);
    check("init_done_level", o_init_done, ok);
    check("init_error_level", o_init_error, !ok);
    if (!ok) check("init_error_code", o_error_code, code);
    tick(3);
  endtask

  task automatic run_op(input bit rd, input bit wr, input logic [31:0] addr, input int st);
    expect_ev(EV_CMD, rd ? 3 : 4, addr, 0);
    card_q.push_back(st);
    if (st == 1) expect_ev(EV_DONE, 0, 0, 0);
    else expect_ev(EV_OPERR, 0, 0, (st < 0) ? 'hF0 : st);
    i_block_addr = addr; i_rd_req = rd; i_wr_req = wr;
    tick(1);
    i_rd_req = 1'b0; i_wr_req = 1'b0; i_block_addr = $urandom;
    tick(1);
    i_wr_req = 1'b1; i_rd_req = 1'($urandom_range(0, 1));
    tick(1);
    i_wr_req = 1'b0; i_rd_req = 1'b0;
    drain(TO + 50, "op_sequence");
    check("init_done_kept", o_init_done, 1);
    check("busy_after_op", o_busy, 0);
    if (st < 0) begin
      check("timeout_latency_in_range",
            (last_operr_cyc - last_cmd_cyc >= TO) && (last_operr_cyc - last_cmd_cyc <= TO + 2), 1);
      check("timeout_code_level", o_error_code, 'hF0);
    end
    tick(2);
  endtask

  initial begin
    int st;
    tick(3);
    check("rst_send_cmd", o_send_cmd, 0);
    check("rst_cmd_select", o_cmd_select, 0);
    check("rst_cmd_arg", o_cmd_arg, 0);
    check("rst_busy", o_busy, 0);
    check("rst_init_done", o_init_done, 0);
    check("rst_init_error", o_init_error, 0);
    check("rst_op_flags", {o_op_done, o_op_error}, 0);
    check("rst_error_code", o_error_code, 0);
    i_rst_n = 1'b1;
    tick(2);

    // requests and confirms in UNINIT are ignored
    i_rd_req = 1'b1; conf_stray = 1'b1;
    tick(1);
    i_rd_req = 1'b0; conf_stray = 1'b0;
    tick(4);
    check("uninit_ignores_req", o_busy, 0);

    run_init(1, -1, 0);

    // read wins over write; then a stray confirm in READY, then random ops
    run_op(1'b1, 1'b1, 32'h0000_0010, 1);
    conf_stray = 1'b1;
    tick(1);
    conf_stray = 1'b0;
    tick(2);
    check("ready_ignores_confirm", o_busy, 0);
    for (int i = 0; i < 8; i++) begin
      st = ($urandom_range(0, 2) != 0) ? 1 : int'($urandom_range(3, 8));
      run_op(1'($urandom_range(0, 1)), 1'b1, $urandom, st);
    end
    run_op(1'b0, 1'b1, $urandom, -1);

    run_init(3, -1, 0);
    run_init(1000, -1, 0);
    for (int i = 0; i < 6; i++)
      run_init(int'($urandom_range(0, 4)),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1,
               int'($urandom_range(3, 8)));
    run_init(0, -1, 0);

    // reset while waiting for the response
    expect_ev(EV_CMD, 3, 32'hA5A5_0001, 0);
    card_q.push_back(-1);
    i_block_addr = 32'hA5A5_0001; i_rd_req = 1'b1;
    tick(1);
    i_rd_req = 1'b0;
    tick(8);
    check("busy_in_wait_rsp", o_busy, 1);
    i_rst_n = 1'b0;
    tick(1);
    check("midcmd_rst_outputs",
          {o_send_cmd, o_cmd_select, o_cmd_arg, o_busy, o_init_done, o_init_error,
           o_op_done, o_op_error, o_error_code}, 0);
    i_rst_n = 1'b1;
    drain(2, "midcmd_cmd_seen");
    for (int i = 0; i < 2; i++) begin
      tick(2);
      conf_stray = 1'b1;
      tick(1);
      conf_stray = 1'b0;
    end
    tick(TO + 20);
    check("after_rst_busy", o_busy, 0);
    check("after_rst_init_done", o_init_done, 0);
    check("after_rst_init_error", o_init_error, 0);

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_card_ctrl.md
SD_CARD_CTRL -- requirements
Module: sd_card_ctrl

Interface
REQ-001 SHALL have parameter POWER_CYCLES, default 80: idle cycles, with no command issued, before the first CMD0.
REQ-002 SHALL have parameter RSP_TIMEOUT, default 4096: maximum cycles from o_send_cmd to the response confirm.
REQ-003 SHALL have parameter ACMD41_RETRIES, default 1000 (16-bit): maximum CMD55/CMD41 pairs.
REQ-004 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 i_rst_n  in  1  reset; synchronous, active-low.
REQ-006 i_start_init  in  1  pulse: begin card initialisation.
REQ-007 i_rd_req / i_wr_req  in  1 each  pulse: issue CMD17 / CMD24 for i_block_addr.
REQ-008 i_block_addr  in  32  block argument, latched at request accept.
REQ-009 o_send_cmd  out  1  one-cycle command strobe to the command engine.
REQ-010 o_cmd_select  out  3  command code: 1=CMD0, 2=CMD16, 3=CMD17, 4=CMD24, 5=CMD55, 7=CMD41.
REQ-011 o_cmd_arg  out  32  command argument.
REQ-012 i_cmd_confirm  in  1  engine pulse; two pulses per command (bits sent, then response ready).
REQ-013 i_cmd_status  in  8  engine status, valid while the 2nd confirm is high: 1=no error, 2=idle, 3..8=error classes.
REQ-014 o_busy, o_init_done, o_init_error  out  1 each  levels.
REQ-015 o_op_done, o_op_error  out  1 each  one-cycle pulses.
REQ-016 o_error_code  out  8  last failing status or internal code.

Function
REQ-017 States SHALL be UNINIT, POWER_WAIT, ISSUE, WAIT_SENT, WAIT_RSP, EVAL, READY, FAIL.
REQ-018 UNINIT or FAIL + i_start_init -> POWER_WAIT; POWER_WAIT SHALL count POWER_CYCLES, then issue CMD0 (arg 0).
REQ-019 ISSUE SHALL assert o_send_cmd for exactly one cycle; o_cmd_select/o_cmd_arg SHALL be stable from ISSUE until EVAL.
REQ-020 WAIT_SENT SHALL consume the 1st confirm; WAIT_RSP SHALL sample i_cmd_status on the 2nd confirm, then go to EVAL.
REQ-021 Timeout counter SHALL start at ISSUE; reaching RSP_TIMEOUT without the 2nd confirm -> error code 8'hF0.
REQ-022 CMD0: status 2 -> CMD55; any other status -> FAIL.
REQ-023 CMD55: status 1 or 2 -> CMD41 (arg 0); any other status -> FAIL.
REQ-024 CMD41: status 1 -> CMD16 (arg 512); status 2 -> decrement retry counter, then CMD55; any other status -> FAIL.
REQ-025 Retry counter SHALL load ACMD41_RETRIES when CMD0 passes; if it is 0 when a retry is needed -> FAIL, code 8'hF1.
REQ-026 CMD16: status 1 -> READY with o_init_done=1; any other status -> FAIL.
REQ-027 FAIL SHALL hold o_init_error=1 and o_error_code until the next i_start_init; i_start_init in FAIL clears o_init_error.
REQ-028 READY SHALL accept i_rd_req (CMD17) or i_wr_req (CMD24); read wins if both are asserted together; i_block_addr latched.
REQ-029 Op result: status 1 -> o_op_done pulse; otherwise (incl. timeout) -> o_op_error pulse with o_error_code=status/8'hF0; both -> READY, o_init_done kept.
REQ-030 i_start_init in READY SHALL clear o_init_done and re-initialise.
REQ-031 Requests SHALL be ignored when not in READY; i_start_init SHALL be ignored outside UNINIT/READY/FAIL.
REQ-032 o_busy SHALL be 0 only in UNINIT, READY and FAIL.
REQ-033 Confirm pulses arriving in UNINIT/READY/FAIL SHALL be ignored.

Reset
REQ-034 When i_rst_n=0 at a clock edge: state UNINIT, all counters 0, all outputs 0 (o_cmd_select=0, o_cmd_arg=0), including mid-command.

Verification
REQ-035 Start, card model returns 2,2,1 (CMD0/55/41), then 1 (CMD16) -> exactly 80 idle cycles, then commands 1,5,7,2 issued; o_init_done=1; CMD16 arg=512.
REQ-036 CMD41 returns 2 three times, then 1 -> four CMD55/CMD41 pairs; then READY.
REQ-037 ACMD41_RETRIES=2, CMD41 always returns 2 -> FAIL, o_init_error=1, o_error_code=8'hF1.
REQ-038 READY; i_rd_req and i_wr_req asserted together, addr 0x00000010 -> CMD17 with arg 0x10; status 1 -> o_op_done for one cycle; CMD24 never issued.
REQ-039 No 2nd confirm after CMD24 -> o_op_error at RSP_TIMEOUT, code 8'hF0; o_init_done still 1.
REQ-040 i_rst_n low during WAIT_RSP -> next cycle UNINIT, all outputs 0; later confirms ignored.
